// File: rtl/stimuli_decomposition_engine.sv
// Greedy per-channel decomposition of stimulus values into symbol-table entries, driving the dot-matrix path.
// Optional macro STIM_DECOMP_BLANK_EN adds a blank gap of BLANK_CYCLES after every shown symbol.
module stimuli_decomposition_engine #(
  parameter int unsigned VAL_W        = 7,
  parameter int unsigned SYM_W        = 5,
  parameter int unsigned DEPTH        = 20,
  parameter int unsigned AW           = 5,
  parameter int unsigned NCH          = 2,
  parameter int unsigned CW           = 1,
  parameter int unsigned CNT_W        = 28,
  parameter int unsigned HOLD_CYCLES  = 150000000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [NCH*VAL_W-1:0]   stim,
  input  logic [NCH-1:0]         colr_in,
  output logic [CW-1:0]          rd_ch,
  output logic [AW-1:0]          rd_addr,
  input  logic [VAL_W+SYM_W-1:0] rd_data,
  output logic                   oe,
  output logic                   colr,
  output logic [SYM_W-1:0]       dot_m,
  output logic                   busy,
  output logic                   done,
  output logic [NCH-1:0]         residue_err
);

  localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0]    CH_LAST   = CW'(NCH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef STIM_DECOMP_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READ,
    S_EVAL,
    S_SHOW,
`ifdef STIM_DECOMP_BLANK_EN
    S_BLANK,
`endif
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] rem;
  logic             mode_r;
  logic             col_lat;
  logic [CNT_W-1:0] cnt;

  logic [VAL_W-1:0] v;
  logic [SYM_W-1:0] s;
  logic [VAL_W-1:0] stim_ch;
  logic             col_ch;
  logic             fit;
  logic             at_end;

  assign v      = rd_data[VAL_W+SYM_W-1:SYM_W];
  assign s      = rd_data[SYM_W-1:0];
  assign fit    = (v != '0) && (v <= rem);
  assign at_end = (rd_addr == (mode_r ? AW'(0) : ADDR_LAST));

  // Select the current channel's stimulus and colour with constant slices only.
  always_comb begin
    stim_ch = '0;
    col_ch  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rd_ch == CW'(c)) begin
        stim_ch = stim[c*VAL_W +: VAL_W];
        col_ch  = colr_in[c];
      end
    end
  end

  // rd_ch/rd_addr double as the channel and scan-address registers so the read port is valid during READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rem         <= '0;
      mode_r      <= 1'b0;
      col_lat     <= 1'b0;
      cnt         <= '0;
      rd_ch       <= '0;
      rd_addr     <= '0;
      oe          <= 1'b0;
      colr        <= 1'b0;
      dot_m       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      residue_err <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r      <= mode;
            rd_ch       <= '0;
            residue_err <= '0;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          rem     <= stim_ch;
          col_lat <= col_ch;
          rd_addr <= mode_r ? ADDR_LAST : AW'(0);
          state   <= (stim_ch == '0) ? S_NEXT : S_READ;
        end
        S_READ: begin
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (fit) begin
            rem   <= rem - v;
            dot_m <= s;
            colr  <= col_lat;
            oe    <= 1'b1;
            cnt   <= '0;
            state <= S_SHOW;
          end else if (at_end) begin
            residue_err[rd_ch] <= 1'b1;
            state              <= S_NEXT;
          end else begin
            rd_addr <= mode_r ? (rd_addr - AW'(1)) : (rd_addr + AW'(1));
            state   <= S_READ;
          end
        end
        S_SHOW: begin
          if (cnt == HOLD_LAST) begin
            oe  <= 1'b0;
            cnt <= '0;
`ifdef STIM_DECOMP_BLANK_EN
            state <= S_BLANK;
`else
            state <= (rem == '0) ? S_NEXT : S_READ;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef STIM_DECOMP_BLANK_EN
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= (rem == '0) ? S_NEXT : S_READ;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        S_NEXT: begin
          if (rd_ch == CH_LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            rd_ch <= rd_ch + CW'(1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stimuli_decomposition_engine.md
# stimuli_decomposition_engine

Parametrised successor to the two-channel stimuli comparison unit. Accepts one stimulus value per channel. Greedily decomposes each value into a sum of entries from that channel's symbol table, scanning the table ascending or descending. Drives each chosen symbol's dot-matrix code and colour to the display path for a programmable hold time. Sits between the stimulus capture logic and the dot-matrix driver, reading the per-channel symbol tables through one shared synchronous read port.

## Interface
- `VAL_W`, default 7: stimulus and table value width.
- `SYM_W`, default 5: dot-matrix symbol code width.
- `DEPTH`, default 20: entries per channel table (≥2).
- `AW`, default 5: table address width; `2^AW ≥ DEPTH`.
- `NCH`, default 2: channel count (≥1).
- `CW`, default 1: channel index width; `2^CW ≥ NCH`.
- `CNT_W`, default 28: hold counter width.
- `HOLD_CYCLES`, default 150000000: cycles each symbol is shown (≥1, fits `CNT_W`).
- `BLANK_CYCLES`, default 1000: blank gap length, used only with the blank feature.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; one clock; asynchronous, active-low.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `mode`, in, 1: 0 = ascending scan (addr 0 → DEPTH-1), 1 = descending scan; latched at start.
- `stim`, in, NCH*VAL_W: channel c occupies bits `[c*VAL_W +: VAL_W]`; latched per channel in LOAD.
- `colr_in`, in, NCH: per-channel colour bit.
- `rd_ch`, out, CW: table channel select.
- `rd_addr`, out, AW: table address.
- `rd_data`, in, VAL_W+SYM_W: `{value, symbol}`; valid one cycle after `rd_ch`/`rd_addr`.
- `oe`, out, 1: display enable.
- `colr`, out, 1: displayed colour.
- `dot_m`, out, SYM_W: displayed symbol.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a run completes.
- `residue_err`, out, NCH: sticky per run; set when a channel's table is exhausted with nonzero remainder.

## Operation
- States: IDLE, LOAD, READ, EVAL, SHOW, BLANK (feature only), NEXT, DONE.
- IDLE:
  - On `start`=1: latch `mode`, set ch=0, clear `residue_err`, go to LOAD.
  - Otherwise remain in IDLE.
- LOAD:
  - Set rem = `stim[ch]` and addr = 0 (ascending) or DEPTH-1 (descending).
  - If rem==0, go to NEXT; else go to READ.
- READ: drive `rd_ch`=ch and `rd_addr`=addr; go to EVAL.
- EVAL: split `rd_data` into value v and symbol s.
  - v≠0 and v ≤ rem:
    - rem ← rem − v (VAL_W-bit unsigned; never underflows).
    - `dot_m` ← s, `colr` ← `colr_in[ch]`.
    - addr is unchanged, so an entry may repeat.
    - Go to SHOW.
  - Otherwise (v==0 counts as an empty entry):
    - If addr is the last address for the scan direction: set `residue_err[ch]`, go to NEXT.
    - Else: step addr by ±1 and go to READ.
- SHOW:
  - `oe`=1 for exactly HOLD_CYCLES cycles; the counter clears on entry.
  - Then go to BLANK if the feature is compiled in, else continue as follows.
  - If rem==0, go to NEXT; else go to READ.
- NEXT:
  - If ch == NCH-1, go to DONE.
  - Else ch ← ch+1 and go to LOAD.
- DONE: `done`=1 for one cycle; go to IDLE.
- `start` while `busy` is ignored.
- `stim` and `colr_in` changes between channels take effect at that channel's LOAD.
- Reset values: state IDLE, `oe`=0, `colr`=0, `dot_m`=0, `rd_ch`=0, `rd_addr`=0, `busy`=0, `done`=0, `residue_err`=0.
- Reset mid-SHOW drops `oe` immediately (asynchronous).

## Timing
- All outputs are registered.
- `rd_data` is sampled in the EVAL cycle, one cycle after READ.
- Latency from `start` to first `oe` rise, match at the first address: 4 cycles. Breakdown: LOAD at cycle 1, READ at 2, EVAL at 3, `oe` high at 4.
- Each non-matching entry costs 2 cycles (READ, EVAL).
- Between consecutive symbols, `oe` is low for ≥2 cycles (READ, EVAL); plus BLANK_CYCLES when the feature is in.
- `dot_m` and `colr` hold their last value while `oe`=0.

## Configuration
- Macro: `STIM_DECOMP_BLANK_EN`.
- Defined: after every SHOW, BLANK holds `oe`=0 for exactly BLANK_CYCLES cycles before the rem check. This gives visible separation of repeated symbols.
- Undefined: the BLANK state and its logic are absent; SHOW proceeds directly to the rem check.

## Test plan
Common bench setup: NCH=2, DEPTH=4, HOLD_CYCLES=3, BLANK feature off.
- Ch0 table {5,A},{3,B},{1,C},{0,–}; stim0=7, stim1=0, mode=0 → `dot_m` sequence A, C, C, each with `oe` high for 3 cycles. Then `done` pulses, `residue_err`=00.
- Same table, mode=1, stim0=4 → addr3 is skipped; output is C×4; `residue_err`=00.
- Ch1 table {4,D},{0},{0},{0}; stim1=6, stim0=0 → D shown once; `residue_err`=10, rem left at 2.
- `start` asserted while `busy` and a `start` pulse during SHOW → no restart; a single `done` per run.
- `rst_n` low mid-SHOW → `oe`, `busy`, and `dot_m` go to 0 within the same cycle; the next `start` runs cleanly from ch0.
- `STIM_DECOMP_BLANK_EN` defined with BLANK_CYCLES=2 and the first scenario → `oe`-low gaps between symbols are exactly 4 cycles.
